// File: rtl/parking_meter_pkg.sv
// Shared types and constants for the parking-meter controller.
package parking_meter_pkg;

    localparam int unsigned COUNT_W = 7;
    localparam int unsigned COIN_W  = 3;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SUM_W   = 8;

    // Seconds of credit per coin switch
    localparam int unsigned COIN_5_SEC  = 5;
    localparam int unsigned COIN_10_SEC = 10;
    localparam int unsigned COIN_20_SEC = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_D0    = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_D1    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_D2    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_D3    = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_D4    = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_D5    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_D6    = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_D7    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_D8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_D9    = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decoder
    import parking_meter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    // Digit lookup
    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0: seg_c = SEG_D0;
            4'd1: seg_c = SEG_D1;
            4'd2: seg_c = SEG_D2;
            4'd3: seg_c = SEG_D3;
            4'd4: seg_c = SEG_D4;
            4'd5: seg_c = SEG_D5;
            4'd6: seg_c = SEG_D6;
            4'd7: seg_c = SEG_D7;
            4'd8: seg_c = SEG_D8;
            4'd9: seg_c = SEG_D9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/parking_meter_ctl.sv
// Parking-meter controller: coin credit, 1 Hz countdown, two-digit display.
// Optional feature macro: PARKING_METER_EXPIRE_FLASH_EN (flash "00" when expired).
module parking_meter_ctl
    import parking_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned MAX_SEC = 99
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COIN_W-1:0] sw_coin,
    input  logic              sw_start,
    output logic [SEG_W-1:0]  seg0,
    output logic [SEG_W-1:0]  seg1
);

    localparam int unsigned PRESC_W = $clog2(CLK_HZ + 1);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_SEC);

    logic [COIN_W-1:0]  coin_meta, coin_sync, coin_prev;
    logic               start_meta, start_sync;
    logic [COIN_W-1:0]  coin_pulse_c;
    logic [5:0]         coin_sum_c;
    state_t             state, state_next_c;
    logic [PRESC_W-1:0] presc;
    logic               tick_c;
    logic [COUNT_W-1:0] count, count_next_c;
    logic [SUM_W-1:0]   sum_c;
    logic [DIGIT_W-1:0] tens_c, ones_c;
    logic [SEG_W-1:0]   tens_seg_c, ones_seg_c;
    logic               blank_c;

    // Two-flop synchronizers plus a history flop for coin edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coin_meta  <= '0;
            coin_sync  <= '0;
            coin_prev  <= '0;
            start_meta <= 1'b0;
            start_sync <= 1'b0;
        end else begin
            coin_meta  <= sw_coin;
            coin_sync  <= coin_meta;
            coin_prev  <= coin_sync;
            start_meta <= sw_start;
            start_sync <= start_meta;
        end
    end

    assign coin_pulse_c = coin_sync & ~coin_prev;
    assign coin_sum_c   = (coin_pulse_c[0] ? 6'(COIN_5_SEC)  : 6'd0)
                        + (coin_pulse_c[1] ? 6'(COIN_10_SEC) : 6'd0)
                        + (coin_pulse_c[2] ? 6'(COIN_20_SEC) : 6'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next_c;
    end

    // Next-state logic
    always_comb begin
        state_next_c = state;
        case (state)
            IDLE: begin
                if (start_sync) state_next_c = (count != '0) ? RUN : EXPIRED;
            end
            RUN: begin
                if (!start_sync)        state_next_c = IDLE;
                else if (count == '0)   state_next_c = EXPIRED;
            end
            EXPIRED: begin
                if (!start_sync)        state_next_c = IDLE;
                else if (count != '0)   state_next_c = RUN;
            end
            default: state_next_c = IDLE;
        endcase
    end

    // One-second prescaler; idles at zero outside RUN so each run starts a full second
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               presc <= '0;
        else if (state != RUN)    presc <= '0;
        else if (tick_c)          presc <= '0;
        else                      presc <= presc + PRESC_W'(1);
    end

    assign tick_c = (state == RUN) && (presc == PRESC_TC);

    // Credit update: add coins, subtract tick, clamp to [0, MAX_SEC]
    always_comb begin
        sum_c        = SUM_W'(count) + SUM_W'(coin_sum_c);
        count_next_c = count;
        if (tick_c && (sum_c != '0)) sum_c = sum_c - SUM_W'(1);
        if (sum_c > SUM_W'(MAX_SEC)) count_next_c = MAX_CNT;
        else                         count_next_c = COUNT_W'(sum_c);
    end

    // Credit register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else        count <= count_next_c;
    end

    assign tens_c = DIGIT_W'(count / COUNT_W'(10));
    assign ones_c = DIGIT_W'(count % COUNT_W'(10));

    seg7_decoder u_dec_tens (.digit(tens_c), .seg_c(tens_seg_c));
    seg7_decoder u_dec_ones (.digit(ones_c), .seg_c(ones_seg_c));

`ifdef PARKING_METER_EXPIRE_FLASH_EN
    logic [PRESC_W-1:0] flash_cnt;

    // 1 s flash phase, restarted on entry to EXPIRED with the digits visible first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   flash_cnt <= '0;
        else if (state != EXPIRED)    flash_cnt <= '0;
        else if (flash_cnt == PRESC_TC) flash_cnt <= '0;
        else                          flash_cnt <= flash_cnt + PRESC_W'(1);
    end

    assign blank_c = (state == EXPIRED) && (flash_cnt >= PRESC_W'(CLK_HZ / 2));
`else
    assign blank_c = 1'b0;
`endif

    // Registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg0 <= SEG_D0;
            seg1 <= SEG_D0;
        end else begin
            seg0 <= blank_c ? SEG_BLANK : ones_seg_c;
            seg1 <= blank_c ? SEG_BLANK : tens_seg_c;
        end
    end

endmodule

// File: tb/tb_parking_meter_ctl.sv
// Directed bench for parking_meter_ctl (default build, CLK_HZ = 10).
module tb_parking_meter_ctl;

    logic       clk;
    logic       reset;
    logic [2:0] sw_coin;
    logic       sw_start;
    logic [6:0] seg0;
    logic [6:0] seg1;

    int total = 0;
    int bad   = 0;

    parking_meter_ctl #(.CLK_HZ(10), .MAX_SEC(99)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_coin  (sw_coin),
        .sw_start (sw_start),
        .seg0     (seg0),
        .seg1     (seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent segment table, {g,f,e,d,c,b,a} active-low
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_disp(input string tag, input int exp_val);
        logic [13:0] want;
        logic [13:0] got;
        want = {seg_of(exp_val / 10), seg_of(exp_val % 10)};
        got  = {seg1, seg0};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (value %0d)", tag, got, want, exp_val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_coin(input int b, input int hold);
        sw_coin[b] = 1'b1;
        step(hold);
        sw_coin[b] = 1'b0;
        step(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        sw_coin  = 3'b000;
        sw_start = 1'b0;
        step(5);
        check_disp("reset_hold", 0);
        reset = 1'b1;
        step(20);
        check_disp("idle_no_dec", 0);

        // Held coin deposits only once
        sw_coin[0] = 1'b1;
        step(50);
        check_disp("hold_once_mid", 5);
        sw_coin[0] = 1'b0;
        step(5);
        check_disp("hold_once_after", 5);
        pulse_coin(1, 5);
        check_disp("coin10", 15);
        step(30);
        check_disp("idle_frozen", 15);

        // Countdown: RUN entered 3 edges after start, first decrement 10 edges later
        sw_start = 1'b1;
        step(13);
        check_disp("pre_first_dec", 15);
        step(1);
        check_disp("first_dec", 14);
        step(20);
        check_disp("at12", 12);

        // Pause for 37 cycles, then resume with a full second before the next decrement
        sw_start = 1'b0;
        step(37);
        check_disp("paused", 12);
        sw_start = 1'b1;
        step(13);
        check_disp("resume_pre", 12);
        step(1);
        check_disp("resume_dec", 11);
        step(120);
        check_disp("expired", 0);
        step(20);
        check_disp("expired_hold", 0);

        // Coin in EXPIRED restarts the countdown
        sw_coin[0] = 1'b1;
        step(4);
        check_disp("exp_coin", 5);
        step(10);
        check_disp("exp_run_pre", 5);
        step(1);
        check_disp("exp_run_dec", 4);
        sw_start   = 1'b0;
        sw_coin[0] = 1'b0;
        step(10);
        check_disp("paused_4", 4);

        // Saturation: 4 + 5*20 clamps at 99
        pulse_coin(2, 3);
        check_disp("sat_24", 24);
        pulse_coin(2, 3);
        pulse_coin(2, 3);
        pulse_coin(2, 3);
        check_disp("sat_84", 84);
        pulse_coin(2, 3);
        check_disp("sat_99", 99);
        pulse_coin(1, 3);
        check_disp("sat_hold", 99);

        // Coin and tick in the same update at count 4
        reset = 1'b0;
        step(2);
        check_disp("reset_clear", 0);
        reset = 1'b1;
        step(2);
        pulse_coin(0, 5);
        check_disp("pre_coin", 5);
        sw_start = 1'b1;
        step(20);
        sw_coin[0] = 1'b1;
        step(3);
        check_disp("at4", 4);
        step(1);
        check_disp("tick_coin", 8);
        sw_coin[0] = 1'b0;
        step(10);
        check_disp("at7", 7);

        // Asynchronous reset mid-countdown
        #2;
        reset = 1'b0;
        #1;
        check_disp("async_reset", 0);
        sw_start = 1'b0;
        step(2);
        reset = 1'b1;
        step(20);
        check_disp("post_reset_idle", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_meter_ctl.md
# parking_meter_ctl

Coin-operated parking-meter controller for the DE10-Lite board: slide switches deposit time credit, a start switch runs a 1 Hz countdown, and the remaining seconds (0–99) are shown on two active-low seven-segment digits. It sits directly under the board top level, driven by the 50 MHz board clock and raw switch inputs. Its outputs go straight to HEX0/HEX1.

## Interface
- CLK_HZ, 50_000_000: clock frequency; sets the one-second prescaler terminal count (CLK_HZ−1).
- MAX_SEC, 99: credit saturation ceiling; must be ≤ 99.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- sw_coin  in  3  raw coin switches: bit0 = 5 s, bit1 = 10 s, bit2 = 20 s; a deposit happens on each 0→1 transition.
- sw_start  in  1  raw level; while high, countdown runs.
- seg0  out  7  ones digit, active-low segments {g,f,e,d,c,b,a}.
- seg1  out  7  tens digit, same encoding.

## Operation
- Inputs: each sw_coin bit and sw_start pass through a 2-FF synchronizer. Coin deposits come from rising-edge detection on the synchronized value, giving a single-cycle pulse.
- Credit register `count`, 7 bits, range 0..MAX_SEC.
- FSM states:
  - IDLE: start_sync=0.
  - RUN: start_sync=1 and count>0.
  - EXPIRED: start_sync=1 and count=0.
- FSM transitions:
  - IDLE→RUN when start_sync=1 and count>0.
  - IDLE→EXPIRED when start_sync=1 and count=0.
  - RUN→EXPIRED when count reaches 0.
  - RUN/EXPIRED→IDLE when start_sync=0.
  - EXPIRED→RUN when a coin raises count above 0.
- Prescaler: counts only in RUN. It clears in IDLE/EXPIRED and on entry to RUN, so the first decrement lands a full CLK_HZ cycles after entering RUN. The terminal count issues a 1-cycle `tick`.
- Per-cycle update: next = count + coin_sum − (tick ? 1 : 0), then clamped to [0, MAX_SEC]. coin_sum is the sum of all edge pulses in that cycle (max 35).
- Coins are accepted in every state, including during countdown.
- Pausing (start low) freezes count. The prescaler residue is discarded.
- Display: tens = count/10 and ones = count%10 (constant-divisor or double-dabble, combinational). Each digit is decoded to active-low segments. Both digits always show, including a leading zero.

## Timing
- Reset (async assert, sync deassert by the board top level): count=0, state=IDLE, prescaler=0, synchronizers=0. seg0=seg1=7'b1000000 ("00").
- Coin latency: switch rises → count updated 3 clk edges later (2 sync + 1 register). seg outputs are registered, so the display follows count 1 cycle later.
- sw_start latency: 2 cycles to start_sync, then 1 cycle to the state change.
- Tick and coin in the same cycle: both apply in a single update (e.g. 4 + 5 − 1 = 8).
- Saturation: 95 + 10 → 99. Credit beyond MAX_SEC is lost.
- Holding a coin switch high deposits once. It must return low and rise again to deposit again.
- Reset mid-countdown: immediate return to "00"/IDLE.

## Configuration
- PARKING_METER_EXPIRE_FLASH_EN defined: in EXPIRED, both digits alternate "00" and blank (7'b1111111) at 1 Hz, 50 % duty. Timing comes from a free-running 1 s phase counter that starts blank-off on entry.
- Not defined: EXPIRED shows steady "00". No flash logic is synthesized.

## Structure
- Package parking_meter_pkg holds:
  - the coin value constants (5, 10, 20);
  - the state enum {IDLE, RUN, EXPIRED};
  - the active-low digit pattern constants 0–9 and BLANK.
- Sub-module seg7_decoder: 4-bit digit in, 7-bit active-low segments out, combinational. It is instantiated twice.

## Test plan
Use CLK_HZ=10 for simulation.
- Reset low 5 cycles, then release → seg1/seg0 = "00", no decrement while sw_start=0.
- Pulse sw_coin[0] then sw_coin[1] (each held 5 cycles) → count=15, display "15". Holding a bit high for 50 cycles still adds only once.
- From 15, raise sw_start → first decrement 10 cycles after RUN entry. After 150 cycles in RUN, count=0 and state=EXPIRED. With the flash macro defined the display blinks; without it, steady "00".
- In RUN at 12, drop sw_start for 37 cycles then raise → count holds 12, and the next decrement comes a full 10 cycles after RUN re-entry.
- Deposit 20 five times → display saturates at "99". Deposit 5 at count=0 in EXPIRED → RUN, display "05".
- Assert reset mid-countdown at 7 → outputs "00" within the same cycle (async). Time a coin edge to coincide with a tick at count=4 → "08".
